// File: rtl/lf_serial_wide_adder_pkg.sv
// Shared types for the serial wide adder: FSM states, default slice width,
// and the slice-index width helper.
package lf_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W_DEFAULT = 10;

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_w(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/lf_serial_wide_adder_if.sv
// Operand/result handshake bundle for lf_serial_wide_adder.
// out_ovf exists only when LF_SERIAL_OVF_EN is defined.
interface lf_serial_wide_adder_if
  import lf_adder_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEFAULT,
  parameter int SLICES  = 4
);
  localparam int W = SLICE_W * SLICES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef LF_SERIAL_OVF_EN
  logic         out_ovf;

  modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                  input  in_ready, out_valid, out_sum, out_cout, out_ovf);
  modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout, out_ovf);
`else
  modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                  input  in_ready, out_valid, out_sum, out_cout);
  modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout);
`endif

endinterface

// File: rtl/lf_serial_wide_adder_slice.sv
// lf_prefix_slice: combinational W-bit Ladner-Fischer G/P prefix adder with carry-in.
// Latency: 0 cycles. Backpressure: none (pure logic).
// Handshake: none; outputs follow inputs.
module lf_prefix_slice #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int LV = (W > 1) ? $clog2(W) : 0;

  logic [W-1:0] p;
  logic [W-1:0] gg;
  logic [W-1:0] pp;
  logic [W:0]   c;

  always_comb begin
    p  = a ^ b;
    gg = a & b;
    // Folding cin into bit 0 makes every prefix group-generate a true carry-out.
    gg[0] = gg[0] | (p[0] & cin);
    pp = p;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < W; i++) begin
        if (((i >> l) & 1) == 1) begin
          gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
          pp[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
      end
    end
    c    = {gg, cin};
    sum  = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/lf_serial_wide_adder.sv
// Serial wide adder: one SLICE_W slice per cycle through a shared prefix adder, LSB first; LF_SERIAL_OVF_EN adds out_ovf.
// Latency: accept in cycle T, out_valid in cycle T+SLICES+1; one op per SLICES+2 cycles.
// Backpressure: out_ready low holds DONE with outputs frozen; in_ready only in IDLE.
module lf_serial_wide_adder
  import lf_adder_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEFAULT,
  parameter int SLICES  = 4
) (
  input logic                  clk,
  input logic                  rst,
  lf_serial_wide_adder_if.slave bus
);
  localparam int W  = SLICE_W * SLICES;
  localparam int IW = idx_w(SLICES);
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  state_e state_q, state_d;

  logic [IW-1:0]      idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_c;
  logic               accept;

  assign sl_a   = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b   = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign accept = (state_q == IDLE) && bus.in_valid;

  lf_prefix_slice #(.W(SLICE_W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN:  if (idx_q == LAST) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LF_SERIAL_OVF_EN
  logic ovf_q;
  assign bus.out_ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef LF_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      carry_q <= bus.in_cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= sl_s;
      carry_q <= sl_c;
      if (idx_q == LAST) begin
        cout_q <= sl_c;
        idx_q  <= '0;
`ifdef LF_SERIAL_OVF_EN
        // Carry into the MSB is recovered as a^b^sum at that bit.
        ovf_q  <= a_q[W-1] ^ b_q[W-1] ^ sl_s[SLICE_W-1] ^ sl_c;
`endif
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign bus.out_sum  = sum_q;
  assign bus.out_cout = cout_q;

endmodule
